johannes_hoff_top: RTL and testbench

//  Minimal 8-bit SAP-1 CPU: 16x8 unified program/data memory, accumulator A, operand register B,
//  4-bit PC, carry/zero flags and an 8-bit output register driven onto the pin bus.
//  The chip-level tile wrapper: all I/O on the 8-in/8-out pin bus; runs a preloaded counter program.

---
 rtl/johannes_hoff_top.sv | 168 ++++++++++++++++
 tb/tb_johannes_hoff_top.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/johannes_hoff_top.sv
// SAP-1 style 8-bit CPU tile: 16x8 memory, A/B/PC/MAR/IR/OUT, CF/ZF, fixed 5-clock instruction cycle.
// Optional macro SAP_DEBUG_VIEW_EN: io_in[2]=1 shows {halted,CF,ZF,0,PC} on io_out.
//
//  state | meaning
//  T0    | MAR <= PC
//  T1    | fetch IR from memory, increment PC
//  T2    | decode: operand address, immediates, jumps, OUT, HLT
//  T3    | memory read into A/B, or store A
//  T4    | ALU writeback with carry/zero flags

module johannes_hoff_top (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic       clk;
    logic       rst;
    logic       unused_pins;

    assign clk = io_in[0];
    assign rst = io_in[1];
    assign unused_pins = &{1'b0, io_in[7:2]};

    tstate_t    t, t_next;
    logic [3:0] pc;
    logic [3:0] mar;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ir;
    logic [7:0] out_r;
    logic       cf;
    logic       zf;
    logic       halted;
    logic [7:0] mem [16];

    logic [3:0] opcode;
    logic [3:0] operand;
    logic [8:0] alu_res;

    assign opcode  = ir[7:4];
    assign operand = ir[3:0];

    // Counter program: counts 1..255 on OUT, wraps to 0 with carry, then halts.
    function automatic logic [7:0] boot_rom(input logic [3:0] addr);
        case (addr)
            4'h0:    boot_rom = 8'h51;
            4'h1:    boot_rom = 8'h4F;
            4'h2:    boot_rom = 8'h50;
            4'h3:    boot_rom = 8'h2F;
            4'h4:    boot_rom = 8'hE0;
            4'h5:    boot_rom = 8'h77;
            4'h6:    boot_rom = 8'h63;
            4'h7:    boot_rom = 8'hF0;
            default: boot_rom = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= T0;
        end else begin
            t <= t_next;
        end
    end

    always_comb begin
        t_next = t;
        if (!halted) begin
            case (t)
                T0:      t_next = T1;
                T1:      t_next = T2;
                T2:      t_next = T3;
                T3:      t_next = T4;
                T4:      t_next = T0;
                default: t_next = T0;
            endcase
        end
    end

    // SUB uses A + ~B + 1 so bit 8 is the "no borrow" carry.
    always_comb begin
        alu_res = {1'b0, a} + {1'b0, b};
        if (opcode == OP_SUB) begin
            alu_res = {1'b0, a} + {1'b0, ~b} + 9'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= 4'h0;
            mar    <= 4'h0;
            a      <= 8'h00;
            b      <= 8'h00;
            ir     <= 8'h00;
            out_r  <= 8'h00;
            cf     <= 1'b0;
            zf     <= 1'b0;
            halted <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem[i] <= boot_rom(4'(i));
            end
        end else if (!halted) begin
            case (t)
                T0: begin
                    mar <= pc;
                end
                T1: begin
                    ir <= mem[mar];
                    pc <= pc + 4'd1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
                        OP_LDI: a <= {4'h0, operand};
                        OP_JMP: pc <= operand;
                        OP_JC:  if (cf) pc <= operand;
                        OP_JZ:  if (zf) pc <= operand;
                        OP_OUT: out_r <= a;
                        OP_HLT: halted <= 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA:         a <= mem[mar];
                        OP_ADD, OP_SUB: b <= mem[mar];
                        OP_STA:         mem[mar] <= a;
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        cf <= alu_res[8];
                        a  <= alu_res[7:0];
                        zf <= (alu_res[7:0] == 8'h00);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SAP_DEBUG_VIEW_EN
    assign io_out = io_in[2] ? {halted, cf, zf, 1'b0, pc} : out_r;
`else
    assign io_out = out_r;
`endif

endmodule

// File: tb/tb_johannes_hoff_top.sv
// Bench for johannes_hoff_top: edge-indexed vector table, full-run reference model, random resets.

module tb_johannes_hoff_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] misc = 6'h00;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int tests = 0;
    int fails = 0;
    int edge_no = 0;

    assign io_in = {misc, rst, clk};

    johannes_hoff_top dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       at_edge;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[13];

    // Expected OUT value after a given edge counted from reset release.
    function automatic logic [7:0] model_out(input int e);
        int n;
        if (e < 23) return 8'h00;
        n = (e - 23) / 20 + 1;
        if (n > 255) return 8'h00;
        return 8'(n);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s edge=%0d got=0x%02h expected=0x%02h", name, edge_no, act, exp);
        end
    endtask

    task automatic randomize_misc();
        misc = 6'($urandom);
`ifdef SAP_DEBUG_VIEW_EN
        misc[0] = 1'b0;
`endif
    endtask

    task automatic step_check(input string name);
        @(posedge clk);
        edge_no++;
        @(negedge clk);
        check(name, io_out, model_out(edge_no));
    endtask

    task automatic hold_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_hold", io_out, 8'h00);
        end
        rst = 1'b0;
        edge_no = 0;
    endtask

    initial begin
        vecs[0]  = '{22,   8'h00};
        vecs[1]  = '{23,   8'h01};
        vecs[2]  = '{42,   8'h01};
        vecs[3]  = '{43,   8'h02};
        vecs[4]  = '{63,   8'h03};
        vecs[5]  = '{82,   8'h03};
        vecs[6]  = '{83,   8'h04};
        vecs[7]  = '{5102, 8'hFE};
        vecs[8]  = '{5103, 8'hFF};
        vecs[9]  = '{5122, 8'hFF};
        vecs[10] = '{5123, 8'h00};
        vecs[11] = '{5133, 8'h00};
        vecs[12] = '{6133, 8'h00};

        // Full program run with every edge checked against the model.
        hold_reset(5);
        for (int v = 0; v < 13; v++) begin
            while (edge_no < vecs[v].at_edge) begin
                if (edge_no % 64 == 0) randomize_misc();
                step_check("run");
            end
            check("vector", io_out, vecs[v].exp);
        end

`ifdef SAP_DEBUG_VIEW_EN
        misc[0] = 1'b1;
        #1;
        check("dbg_halt", io_out, 8'hE8);
        misc[0] = 1'b0;
        #1;
        check("dbg_off", io_out, 8'h00);

        hold_reset(2);
        misc[0] = 1'b1;
        @(posedge clk); edge_no++;
        @(posedge clk); edge_no++;
        @(negedge clk);
        check("dbg_pc1", io_out, 8'h01);
        misc[0] = 1'b0;
`endif

        // Random-length runs interrupted by an asynchronous reset between edges.
        for (int r = 0; r < 6; r++) begin
            int k;
            hold_reset(1 + int'($urandom_range(0, 2)));
            k = int'($urandom_range(30, 300));
            randomize_misc();
            while (edge_no < k) step_check("rand_run");
            #2;
            rst = 1'b1;
            #1;
            check("async_rst", io_out, 8'h00);
            hold_reset(1 + int'($urandom_range(0, 2)));
            while (edge_no < 25) step_check("restart");
            check("restart_val", io_out, 8'h01);
        end

        // Back-to-back single-clock reset pulses never let the output move.
        for (int p = 0; p < 8; p++) begin
            hold_reset(1);
            for (int s = 0; s < 2; s++) step_check("pulse");
            check("pulse_zero", io_out, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
